// File: rtl/link_pkg.sv
// -----------------------------------------------------------------------------
// link_pkg: word constants and framer states shared by both ends of the link.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package link_pkg;

  localparam int LINK_BW = 64;

  localparam logic [LINK_BW-1:0] LINK_SYNC_WORD = 64'hD5A5_5A5A_A55A_5AD5;
  localparam logic [LINK_BW-1:0] LINK_IDLE_WORD = 64'h0707_0707_0707_0707;

  typedef enum logic [1:0] {
    TRAIN   = 2'd0,
    PAYLOAD = 2'd1,
    SYNC    = 2'd2
  } link_state_t;

endpackage

`default_nettype wire

// File: rtl/word_frame_oreg.sv
// -----------------------------------------------------------------------------
// word_frame_oreg: word+mark output register that holds under back-pressure.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module word_frame_oreg #(
  parameter int BW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [BW-1:0] d_word,
  input  logic          d_mark,
  input  logic          pull,
  output logic          adv,
  output logic [BW-1:0] q_word,
  output logic          q_mark,
  output logic          valid
);

  assign adv = ~valid | pull;

  // Once valid, every advance reloads; the line is never left empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_word <= '0;
      q_mark <= 1'b0;
      valid  <= 1'b0;
    end else if (adv) begin
      q_word <= d_word;
      q_mark <= d_mark;
      valid  <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/word_frame.sv
// -----------------------------------------------------------------------------
// word_frame: training burst, periodic sync insertion and idle fill for the link.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module word_frame
  import link_pkg::*;
#(
  parameter int            BW        = LINK_BW,
  parameter int            FRAME_LEN = 256,
  parameter int            TRAIN_LEN = 64,
  parameter logic [BW-1:0] SYNC_WORD = LINK_SYNC_WORD,
  parameter logic [BW-1:0] IDLE_WORD = LINK_IDLE_WORD
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init,
  input  logic [BW-1:0] din,
  input  logic          dipush,
  output logic          dipull,
  output logic [BW-1:0] dout,
  output logic          dopush,
  input  logic          dopull,
  output logic          sync_mark,
  output logic          training,
  output logic          collide
);

  localparam int FW = $clog2(FRAME_LEN + 1);
  localparam int TW = $clog2(TRAIN_LEN + 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_LEN - 1);
  localparam logic [TW-1:0] TRAIN_LAST = TW'(TRAIN_LEN - 1);

  link_state_t   state, state_n;
  logic [TW-1:0] train_cnt, train_n;
  logic [FW-1:0] pay_cnt, pay_n;
  logic          collide_n;
  logic          adv;
  logic [BW-1:0] load_word;
  logic          load_mark;

  assign dipull   = adv & dipush & (state == PAYLOAD);
  assign training = (state == TRAIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= TRAIN;
      train_cnt <= '0;
      pay_cnt   <= '0;
      collide   <= 1'b0;
    end else begin
      state     <= state_n;
      train_cnt <= train_n;
      pay_cnt   <= pay_n;
      collide   <= collide_n;
    end
  end

  // Sync is the default load; a retrain that catches no payload keeps the line in sync words.
  always_comb begin
    state_n   = state;
    train_n   = train_cnt;
    pay_n     = pay_cnt;
    collide_n = collide;
    load_word = SYNC_WORD;
    load_mark = 1'b1;

    if (dipull) begin
      load_word = din;
      load_mark = 1'b0;
      if (din == SYNC_WORD) collide_n = 1'b1;
    end

    unique case (state)
      TRAIN: begin
        if (init) begin
          train_n   = '0;
          collide_n = 1'b0;
        end else if (adv) begin
          if (train_cnt == TRAIN_LAST) begin
            state_n = PAYLOAD;
            train_n = '0;
            pay_n   = '0;
          end else begin
            train_n = train_cnt + TW'(1);
          end
        end
      end
      PAYLOAD: begin
        if (init) begin
          state_n = TRAIN;
          train_n = '0;
          pay_n   = '0;
        end else if (adv) begin
          if (dipull) begin
            pay_n = pay_cnt + FW'(1);
            if (pay_cnt == FRAME_LAST) state_n = SYNC;
          end else begin
            load_word = IDLE_WORD;
            load_mark = 1'b0;
          end
        end
      end
      SYNC: begin
        if (init) begin
          state_n = TRAIN;
          train_n = '0;
          pay_n   = '0;
        end else if (adv) begin
          state_n = PAYLOAD;
          pay_n   = '0;
        end
      end
      default: begin
        state_n = TRAIN;
        train_n = '0;
        pay_n   = '0;
      end
    endcase
  end

  word_frame_oreg #(
    .BW(BW)
  ) u_oreg (
    .clk   (clk),
    .rst   (rst),
    .d_word(load_word),
    .d_mark(load_mark),
    .pull  (dopull),
    .adv   (adv),
    .q_word(dout),
    .q_mark(sync_mark),
    .valid (dopush)
  );

endmodule

`default_nettype wire

// File: tb/tb_word_frame.sv
// -----------------------------------------------------------------------------
// tb_word_frame: randomized scenarios against a counting reference of the framer.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_word_frame;
  import link_pkg::*;

  localparam int FRAME_LEN = 3;
  localparam int TRAIN_LEN = 4;

  logic        clk = 1'b0;
  logic        rst, init, dipush, dopull;
  logic        dipull, dopush, sync_mark, training, collide;
  logic [63:0] din, dout;

  int checks = 0;
  int errors = 0;

  // Reference: remaining training words, frame payload count, pending-sync flag.
  bit          m_valid, m_mark, m_collide, sync_due, exp_dipull, obs_dipull;
  logic [63:0] m_word;
  int          train_left, frame_count;

  word_frame #(
    .BW       (64),
    .FRAME_LEN(FRAME_LEN),
    .TRAIN_LEN(TRAIN_LEN),
    .SYNC_WORD(LINK_SYNC_WORD),
    .IDLE_WORD(LINK_IDLE_WORD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .init     (init),
    .din      (din),
    .dipush   (dipush),
    .dipull   (dipull),
    .dout     (dout),
    .dopush   (dopush),
    .dopull   (dopull),
    .sync_mark(sync_mark),
    .training (training),
    .collide  (collide)
  );

  always #5 clk = ~clk;

  function automatic logic [68:0] obs_vec();
    return {dopush, sync_mark, training, collide, obs_dipull, dout};
  endfunction

  function automatic logic [68:0] exp_vec();
    return {m_valid, m_mark, (train_left > 0), m_collide, exp_dipull, m_word};
  endfunction

  task automatic model_reset();
    m_valid = 0; m_mark = 0; m_collide = 0; m_word = '0;
    sync_due = 0; exp_dipull = 0; obs_dipull = 0;
    train_left = TRAIN_LEN; frame_count = 0;
  endtask

  // Drive one cycle, sample the combinational accept, advance the reference.
  task automatic tick(input bit i, input bit p, input logic [63:0] d, input bit q);
    bit adv, xfer;
    init = i; dipush = p; din = d; dopull = q;
    #3;
    obs_dipull = dipull;
    adv  = !m_valid || q;
    xfer = adv && p && (train_left == 0) && !sync_due;
    exp_dipull = xfer;
    if (xfer) begin
      m_word = d; m_mark = 0; m_valid = 1;
      if (d == LINK_SYNC_WORD) m_collide = 1;
      frame_count++;
    end
    if (train_left > 0) begin
      if (i) m_collide = 0;
      if (adv) begin m_word = LINK_SYNC_WORD; m_mark = 1; m_valid = 1; end
      if (i) train_left = TRAIN_LEN;
      else if (adv) begin train_left--; frame_count = 0; end
    end else if (i) begin
      if (adv && !xfer) begin m_word = LINK_SYNC_WORD; m_mark = 1; m_valid = 1; end
      train_left = TRAIN_LEN; sync_due = 0; frame_count = 0;
    end else if (sync_due) begin
      if (adv) begin
        m_word = LINK_SYNC_WORD; m_mark = 1; m_valid = 1;
        sync_due = 0; frame_count = 0;
      end
    end else if (adv && !xfer) begin
      m_word = LINK_IDLE_WORD; m_mark = 0; m_valid = 1;
    end else if (xfer && frame_count == FRAME_LEN) begin
      sync_due = 1;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rnd_word();
    logic [63:0] w;
    w = {$urandom, $urandom};
    if (w == LINK_SYNC_WORD) w = ~w;
    return w;
  endfunction

  task automatic test_reset();
    rst = 1; init = 0; dipush = 0; dopull = 1; din = '0;
    #12;
    checks++;
    if ({dout, dopush, sync_mark, training, collide} !== {64'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset got dout=%h push=%b mark=%b trn=%b col=%b", dout, dopush, sync_mark, training, collide);
    end
    @(posedge clk); #1;
    rst = 0;
    model_reset();
  endtask

  task automatic test_training();
    for (int k = 0; k < 8; k++) begin
      tick(0, 0, '0, 1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL training cyc %0d got %h exp %h", k, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_frames();
    for (int k = 0; k < 10; k++) begin
      tick(0, 1, rnd_word(), 1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL frames cyc %0d got %h exp %h", k, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_idle_gap();
    bit pat [8] = '{1, 0, 0, 1, 1, 1, 0, 1};
    for (int k = 0; k < 8; k++) begin
      tick(0, pat[k], rnd_word(), 1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL idle_gap cyc %0d got %h exp %h", k, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_backpressure();
    bit pull [9] = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
    for (int k = 0; k < 9; k++) begin
      tick(0, 1, rnd_word(), pull[k]);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL backpressure cyc %0d got %h exp %h", k, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_init();
    for (int k = 0; k < 16; k++) begin
      if (k < 2) tick(0, 1, rnd_word(), 1);
      else if (k < 7) tick(1, 0, '0, 1);
      else tick(0, 1, rnd_word(), 1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL init cyc %0d got %h exp %h", k, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_collide();
    for (int k = 0; k < 16; k++) begin
      if (k == 1) tick(0, 1, LINK_SYNC_WORD, 1);
      else if (k == 6 || k == 7) tick(1, 0, '0, 1);
      else tick(0, 1, rnd_word(), 1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL collide cyc %0d got %h exp %h", k, obs_vec(), exp_vec());
      end
    end
    tick(0, 1, LINK_SYNC_WORD, 1);
    tick(0, 1, rnd_word(), 1);
    rst = 1;
    #2;
    checks++;
    if ({dout, dopush, sync_mark, training, collide} !== {64'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL async_reset got dout=%h push=%b mark=%b trn=%b col=%b", dout, dopush, sync_mark, training, collide);
    end
    @(posedge clk); #1;
    rst = 0;
    model_reset();
  endtask

  task automatic test_random();
    bit i, p, q;
    logic [63:0] d;
    for (int k = 0; k < 400; k++) begin
      i = ($urandom_range(0, 30) == 0);
      p = ($urandom_range(0, 3) != 0);
      q = ($urandom_range(0, 4) != 0);
      d = ($urandom_range(0, 15) == 0) ? LINK_SYNC_WORD : rnd_word();
      tick(i, p, d, q);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc %0d got %h exp %h", k, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_training();
    test_frames();
    test_idle_gap();
    test_backpressure();
    test_init();
    test_collide();
    test_training();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
